// File: rtl/rc4_dispatch_pkg.sv
// Shared types and constants for the RC4 key dispatcher.
package rc4_dispatch_pkg;

  localparam int DEFAULT_KEY_WIDTH = 24;

  localparam logic [9:0] LED_IDLE   = 10'd0;
  localparam logic [9:0] LED_SEARCH = 10'd1;
  localparam logic [9:0] LED_FOUND  = 10'd3;
  localparam logic [9:0] LED_FAIL   = 10'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the rotating pointer,
// pointer moves just past the granted index when advance is strobed.
module rr_arbiter #(
  parameter  int NUM_CORES = 4,
  localparam int IW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  input  logic                 advance,
  output logic [NUM_CORES-1:0] gnt,
  output logic                 vld
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  always_comb begin : pick
    int j;
    j   = 0;
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      j = (int'(ptr) + i) % NUM_CORES;
      if (!vld && req[j]) begin
        gnt[j] = 1'b1;
        vld    = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= '0;
    else if (advance && vld)
      ptr <= (idx == IW'(NUM_CORES - 1)) ? '0 : idx + 1'b1;
  end

endmodule

// File: rtl/rc4_key_dispatcher.sv
// Hands consecutive keys to NUM_CORES decrypt cores via per-core handshakes and
// stops on the first success or when keys 0..KEY_LIMIT-1 are all rejected.
module rc4_key_dispatcher
  import rc4_dispatch_pkg::*;
#(
  parameter  int                 NUM_CORES = 4,
  parameter  int                 KEY_WIDTH = DEFAULT_KEY_WIDTH,
  parameter  logic [KEY_WIDTH:0] KEY_LIMIT = 'h400000,
  localparam int                 CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [NUM_CORES-1:0]                core_done,
  input  logic [NUM_CORES-1:0]                core_success,
  output logic [NUM_CORES-1:0]                core_start,
  output logic [NUM_CORES-1:0][KEY_WIDTH-1:0] core_key,
  output logic                                abort,
  output logic                                busy,
  output logic                                found,
  output logic                                exhausted,
  output logic [KEY_WIDTH-1:0]                found_key,
  output logic [CW-1:0]                       found_core,
  output logic [9:0]                          LEDR
);

  state_t               state, state_d;
  logic [NUM_CORES-1:0] core_busy, done_ok, done_fail, req, gnt;
  logic                 gnt_vld, active, keys_left, any_ok, dispatch, rearm;
  logic [KEY_WIDTH:0]   next_key, next_key_inc;
  logic [CW-1:0]        win_idx;

  assign active       = (state == S_DISPATCH) || (state == S_DRAIN);
  assign done_ok      = core_done & core_success & core_busy & {NUM_CORES{active}};
  assign done_fail    = core_done & ~core_success & core_busy;
  assign any_ok       = |done_ok;
  assign keys_left    = next_key < KEY_LIMIT;
  assign next_key_inc = next_key + 1'b1;
  assign req          = ~core_busy & {NUM_CORES{(state == S_DISPATCH) && keys_left}};
  // A success in the same cycle suppresses any dispatch so no core starts after it.
  assign dispatch     = gnt_vld && !any_ok;
  assign rearm        = start && (state == S_IDLE || state == S_FOUND || state == S_EXHAUSTED);

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (dispatch),
    .gnt     (gnt),
    .vld     (gnt_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (done_ok[i]) win_idx = CW'(i);
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_FOUND, S_EXHAUSTED: if (start) state_d = S_DISPATCH;
      S_DISPATCH: begin
        if (any_ok)
          state_d = S_FOUND;
        else if (!keys_left || (dispatch && next_key_inc >= KEY_LIMIT))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (any_ok)
          state_d = S_FOUND;
        else if ((core_busy & ~done_fail) == '0)
          state_d = S_EXHAUSTED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      core_busy  <= '0;
      next_key   <= '0;
      core_start <= '0;
      core_key   <= '0;
      found_key  <= '0;
      found_core <= '0;
    end else begin
      state      <= state_d;
      core_start <= dispatch ? gnt : '0;
      if (rearm) begin
        next_key   <= '0;
        core_busy  <= '0;
        found_key  <= '0;
        found_core <= '0;
      end else if (active) begin
        core_busy <= (core_busy & ~done_fail) | (dispatch ? gnt : '0);
        if (dispatch) next_key <= next_key_inc;
        if (any_ok) begin
          found_key  <= core_key[win_idx];
          found_core <= win_idx;
        end
      end
      for (int i = 0; i < NUM_CORES; i++)
        if (dispatch && gnt[i]) core_key[i] <= next_key[KEY_WIDTH-1:0];
    end
  end

  assign abort     = (state == S_FOUND);
  assign found     = (state == S_FOUND);
  assign exhausted = (state == S_EXHAUSTED);
  assign busy      = active;

  always_comb begin
    case (state)
      S_DISPATCH, S_DRAIN: LEDR = LED_SEARCH;
      S_FOUND:             LEDR = LED_FOUND;
      S_EXHAUSTED:         LEDR = LED_FAIL;
      default:             LEDR = LED_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
// Bench for rc4_key_dispatcher: behavioural core array plus an in-order key scoreboard.
module tb_rc4_key_dispatcher;

  localparam int NC = 4;
  localparam int KW = 24;
  localparam int NK = 40;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [NC-1:0]      core_done = '0;
  logic [NC-1:0]      core_success = '0;
  logic [NC-1:0]      core_start;
  logic [NC-1:0][KW-1:0] core_key;
  logic               abort, busy, found, exhausted;
  logic [KW-1:0]      found_key;
  logic [1:0]         found_core;
  logic [9:0]         LEDR;

  rc4_key_dispatcher #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_LIMIT(25'd40)) dut (
    .clk(clk), .reset(reset), .start(start),
    .core_done(core_done), .core_success(core_success),
    .core_start(core_start), .core_key(core_key),
    .abort(abort), .busy(busy), .found(found), .exhausted(exhausted),
    .found_key(found_key), .found_core(found_core), .LEDR(LEDR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // core model and scoreboard
  int          lat[NC];
  int          succ_key[NC];
  bit          m_busy[NC];
  logic [KW-1:0] m_key[NC];
  int          m_cnt[NC];
  int          exp_q[$];
  int          disp_cnt[64];

  int first_start_n, first_start_core, succ_done_n, last_done_n;
  int found_n, exh_n, starts_after, starts_seen;
  logic busy_at1;
  logic [9:0] led_at1, led_end;
  logic [KW-1:0] fkey_obs;
  logic [1:0] fcore_obs;
  logic abort_obs;

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; core_done = '0; core_success = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Pulses start, then runs the core model cycle by cycle (inputs driven and
  // outputs sampled at negedge) until found/exhausted settles, stop_starts
  // dispatches are seen, or the budget runs out.
  task automatic run_search(input int stop_starts, input int budget);
    bit stopped = 0;
    int end_n;
    for (int i = 0; i < NC; i++) begin m_busy[i] = 0; m_cnt[i] = 0; m_key[i] = '0; end
    exp_q.delete();
    for (int k = 0; k < NK; k++) exp_q.push_back(k);
    for (int k = 0; k < 64; k++) disp_cnt[k] = 0;
    first_start_n = -1; first_start_core = -1; succ_done_n = -1; last_done_n = -1;
    found_n = -1; exh_n = -1; starts_after = 0; starts_seen = 0;
    @(negedge clk);
    start = 1'b1; core_done = '0; core_success = '0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) begin busy_at1 = busy; led_at1 = LEDR; end
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          starts_seen++;
          if (first_start_n < 0) begin first_start_n = n; first_start_core = i; end
          if (succ_done_n >= 0) starts_after++;
          checks++;
          if (m_busy[i]) begin
            errors++;
            $display("FAIL start_on_busy core %0d cycle %0d", i, n);
          end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_dispatch core %0d key %0d", i, core_key[i]);
          end else begin
            int e;
            e = exp_q.pop_front();
            if (core_key[i] !== KW'(e)) begin
              errors++;
              $display("FAIL dispatch_key core %0d got %0d want %0d", i, core_key[i], e);
            end
          end
          if (core_key[i] < 64) disp_cnt[core_key[i]]++;
          m_busy[i] = 1; m_key[i] = core_key[i]; m_cnt[i] = lat[i];
        end else if (m_busy[i]) begin
          checks++;
          if (core_key[i] !== m_key[i]) begin
            errors++;
            $display("FAIL key_stable core %0d got %0d want %0d", i, core_key[i], m_key[i]);
          end
        end
      end
      if (found && found_n < 0) begin
        found_n = n; fkey_obs = found_key; fcore_obs = found_core; abort_obs = abort; led_end = LEDR;
      end
      if (exhausted && exh_n < 0) begin exh_n = n; led_end = LEDR; end
      if (stop_starts > 0 && starts_seen >= stop_starts) begin stopped = 1; break; end
      end_n = (found_n >= 0) ? found_n : exh_n;
      if (end_n >= 0 && n >= end_n + 4) begin stopped = 1; break; end
      core_done = '0; core_success = '0;
      for (int i = 0; i < NC; i++) begin
        if (m_busy[i]) begin
          if (m_cnt[i] <= 1) begin
            core_done[i] = 1'b1;
            core_success[i] = (succ_key[i] >= 0) && (int'(m_key[i]) == succ_key[i]);
            if (core_success[i] && succ_done_n < 0) succ_done_n = n;
            last_done_n = n;
            m_busy[i] = 0;
          end else m_cnt[i]--;
        end
      end
    end
    core_done = '0; core_success = '0;
    if (!stopped) begin
      checks++; errors++;
      $display("FAIL run_timeout no end after %0d cycles", budget);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({core_start, core_key, abort, busy, found, exhausted, found_key, found_core, LEDR} !== '0) begin
      errors++;
      $display("FAIL %s outputs not zero: start=%b busy=%b found=%b exh=%b led=%0d fkey=%0d",
               name, core_start, busy, found, exhausted, LEDR, found_key);
    end
  endtask

  task automatic check_exhaust(input string name);
    int bad = 0;
    for (int k = 0; k < 64; k++) if (disp_cnt[k] != ((k < NK) ? 1 : 0)) bad++;
    checks++;
    if (bad != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_union bad_keys %0d undispatched %0d want 0 0", name, bad, exp_q.size());
    end
    checks++;
    if (exh_n < 0 || exh_n != last_done_n + 1) begin
      errors++;
      $display("FAIL %s_exh_timing got cycle %0d want %0d", name, exh_n, last_done_n + 1);
    end
    checks++;
    if (led_end !== 10'd4 || found_n >= 0) begin
      errors++;
      $display("FAIL %s_led got %0d found_n %0d want 4 -1", name, led_end, found_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    check_all_zero("reset_state");
    do_reset();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_exhaust();
    do_reset();
    lat = '{3, 3, 3, 3}; succ_key = '{-1, -1, -1, -1};
    run_search(0, 400);
    checks++;
    if (busy_at1 !== 1'b1 || led_at1 !== 10'd1 || first_start_n != 2 || first_start_core != 0) begin
      errors++;
      $display("FAIL start_timing busy1=%b led1=%0d first=%0d core=%0d want 1 1 2 0",
               busy_at1, led_at1, first_start_n, first_start_core);
    end
    check_exhaust("exhaust");
  endtask

  task automatic test_found();
    do_reset();
    lat = '{3, 3, 3, 3}; succ_key = '{-1, -1, 6, -1};
    run_search(0, 400);
    checks++;
    if (succ_done_n < 0 || found_n != succ_done_n + 1) begin
      errors++;
      $display("FAIL found_timing got %0d want %0d", found_n, succ_done_n + 1);
    end
    checks++;
    if (fkey_obs !== 24'd6 || fcore_obs !== 2'd2 || abort_obs !== 1'b1 || led_end !== 10'd3) begin
      errors++;
      $display("FAIL found_result key=%0d core=%0d abort=%b led=%0d want 6 2 1 3",
               fkey_obs, fcore_obs, abort_obs, led_end);
    end
    checks++;
    if (starts_after != 0) begin
      errors++;
      $display("FAIL found_no_start got %0d starts want 0", starts_after);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (found !== 1'b0 || abort !== 1'b0 || busy !== 1'b1 || LEDR !== 10'd1 || found_key !== '0) begin
      errors++;
      $display("FAIL rearm found=%b abort=%b busy=%b led=%0d fkey=%0d want 0 0 1 1 0",
               found, abort, busy, LEDR, found_key);
    end
  endtask

  task automatic test_dual_success();
    do_reset();
    lat = '{3, 5, 3, 3}; succ_key = '{-1, 1, -1, 3};
    run_search(0, 400);
    checks++;
    if (fkey_obs !== 24'd1 || fcore_obs !== 2'd1 || found_n != succ_done_n + 1) begin
      errors++;
      $display("FAIL dual_success key=%0d core=%0d cyc=%0d want 1 1 %0d",
               fkey_obs, fcore_obs, found_n, succ_done_n + 1);
    end
    checks++;
    if (starts_after != 0) begin
      errors++;
      $display("FAIL dual_no_start got %0d starts want 0", starts_after);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = '{3, 3, 3, 3}; succ_key = '{-1, -1, -1, -1};
    run_search(9, 200);
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_search(1, 20);
    checks++;
    if (first_start_n != 2 || first_start_core != 0) begin
      errors++;
      $display("FAIL restart_after_reset cycle=%0d core=%0d want 2 0", first_start_n, first_start_core);
    end
  endtask

  task automatic test_ignored_inputs();
    do_reset();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    core_done = 4'hf; core_success = 4'hf;
    @(negedge clk);
    core_done = '0; core_success = '0;
    checks++;
    if (core_start !== 4'b0001 || core_key[0] !== '0 || found !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL idle_done start=%b key0=%0d found=%b busy=%b want 0001 0 0 1",
               core_start, core_key[0], found, busy);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (core_start !== 4'b0010 || core_key[1] !== 24'd1) begin
      errors++;
      $display("FAIL busy_start_a start=%b key1=%0d want 0010 1", core_start, core_key[1]);
    end
    @(negedge clk);
    checks++;
    if (core_start !== 4'b0100 || core_key[2] !== 24'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_b start=%b key2=%0d busy=%b want 0100 2 1", core_start, core_key[2], busy);
    end
  endtask

  task automatic test_unequal_latency();
    do_reset();
    lat = '{2, 5, 9, 13}; succ_key = '{-1, -1, -1, -1};
    run_search(0, 600);
    check_exhaust("unequal");
  endtask

  initial begin
    test_reset();
    test_exhaust();
    test_found();
    test_dual_success();
    test_reset_mid();
    test_ignored_inputs();
    test_unequal_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
